// File: rtl/quad_pkg.sv
// Shared constants and FSM state encoding for the quadrature velocity block.
package quad_pkg;

    localparam int unsigned WIDTH           = 32;
    localparam int unsigned STALL_CNT_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/quad_velocity_if.sv
// Measurement bus between the quadrature decoder side and the velocity block.
interface quad_velocity_if #(
    parameter int unsigned WIDTH = quad_pkg::WIDTH
) ();

    logic [WIDTH-1:0] count;
    logic [31:0]      period;
    logic [WIDTH-1:0] velocity;
    logic [WIDTH-1:0] position;
    logic             valid;
    logic             stalled;

    modport master (
        output count,
        output period,
        input  velocity,
        input  position,
        input  valid,
        input  stalled
    );

    modport slave (
        input  count,
        input  period,
        output velocity,
        output position,
        output valid,
        output stalled
    );

endinterface

// File: rtl/period_timer.sv
// Reloadable down-counter; expire is high while the count sits at 1 (last cycle of a window).
module period_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q > WIDTH'(1))) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/quad_velocity.sv
// Windowed velocity measurement of a quadrature position count with stall detection.
module quad_velocity #(
    parameter int unsigned WIDTH         = quad_pkg::WIDTH,
    parameter int unsigned STALL_WINDOWS = 4
) (
    input logic            clk,
    input logic            reset,
    quad_velocity_if.slave bus
);

    import quad_pkg::*;

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = STALL_CNT_WIDTH'(STALL_WINDOWS);

    state_e                     state_q, state_d;
    logic [WIDTH-1:0]           prev_q;
    logic [WIDTH-1:0]           velocity_q;
    logic [WIDTH-1:0]           position_q;
    logic                       valid_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [WIDTH-1:0]           delta;
    logic                       expire;
    logic                       sample;
    logic                       timer_load;

    // Modular subtraction gives the correct signed delta across count wrap.
    assign delta = bus.count - prev_q;

    period_timer #(
        .WIDTH (32)
    ) u_timer (
        .clk        (clk),
        .load       (timer_load),
        .load_value (bus.period),
        .enable     (state_q == ST_RUN),
        .expire     (expire)
    );

    always_comb begin
        state_d     = state_q;
        sample      = 1'b0;
        timer_load  = reset;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                timer_load = 1'b1;
                if (bus.period != 32'd0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (expire) begin
                    sample     = 1'b1;
                    timer_load = 1'b1;
                    if (bus.period == 32'd0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        if (sample) begin
            if (delta == '0) begin
                if (stall_cnt_q < STALL_MAX) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end else begin
                stall_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= (bus.period != 32'd0) ? ST_RUN : ST_IDLE;
            prev_q      <= bus.count;
            velocity_q  <= '0;
            position_q  <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= sample;
            stall_cnt_q <= stall_cnt_d;
            if (sample) begin
                velocity_q <= delta;
                position_q <= bus.count;
            end
            // Idle tracks the count so a window opened later starts from a fresh base.
            if (sample || (state_q == ST_IDLE)) begin
                prev_q <= bus.count;
            end
        end
    end

    assign bus.velocity = velocity_q;
    assign bus.position = position_q;
    assign bus.valid    = valid_q;
    assign bus.stalled  = (stall_cnt_q == STALL_MAX);

endmodule

// File: tb/tb_quad_velocity.sv
// Self-checking bench for quad_velocity: directed scenarios plus randomized traffic
// against a deadline-based reference model of the windowed measurement.
module tb_quad_velocity;

    localparam int unsigned SW = 4;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    quad_velocity_if #(.WIDTH(32)) bus ();

    quad_velocity #(
        .WIDTH         (32),
        .STALL_WINDOWS (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a window opens at edge s with length P and closes at edge s+P.
    longint      e          = 0;
    logic        m_active   = 1'b0;
    logic [31:0] m_prev     = '0;
    longint      m_deadline = 0;
    int          m_zero     = 0;
    logic [31:0] exp_vel    = '0;
    logic [31:0] exp_pos    = '0;
    logic        exp_valid  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        exp_valid = 1'b0;
        if (reset) begin
            exp_vel    = '0;
            exp_pos    = '0;
            m_zero     = 0;
            m_active   = (bus.period != 0);
            m_prev     = bus.count;
            m_deadline = e + longint'(bus.period);
        end else if (!m_active) begin
            m_prev = bus.count;
            if (bus.period != 0) begin
                m_active   = 1'b1;
                m_deadline = e + longint'(bus.period);
            end
        end else if (e == m_deadline) begin
            exp_vel   = bus.count - m_prev;
            exp_pos   = bus.count;
            exp_valid = 1'b1;
            m_prev    = bus.count;
            if (exp_vel == 0) begin
                if (m_zero < int'(SW)) m_zero++;
            end else begin
                m_zero = 0;
            end
            if (bus.period == 0) m_active = 1'b0;
            else m_deadline = e + longint'(bus.period);
        end
        e++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("valid", 32'(bus.valid), 32'(exp_valid));
        chk("velocity", bus.velocity, exp_vel);
        chk("position", bus.position, exp_pos);
        chk("stalled", 32'(bus.stalled), 32'(m_zero >= int'(SW)));
    endtask

    // Ticks (adding step to count before each edge) until valid, bounded by budget.
    task automatic wait_valid(input int budget, input int step, output int n);
        n = 0;
        do begin
            bus.count = bus.count + 32'(step);
            tick();
            n++;
        end while (!bus.valid && n < budget);
        chk("wait_valid", 32'(bus.valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nv;
        int r;
        bit frozen;

        // Reset state and +1/clk ramp with period 10
        reset = 1'b1; bus.count = 32'd100; bus.period = 32'd10;
        tick(); tick();
        chk("rst_velocity", bus.velocity, 32'd0);
        chk("rst_position", bus.position, 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_stalled", 32'(bus.stalled), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_valid(12, 1, n);
            chk("ramp_gap", 32'(n), 32'd10);
            chk("ramp_vel", bus.velocity, 32'd10);
            chk("ramp_pos", bus.position, 32'(100 + 10 * k));
        end

        // Upward wrap across 0x7FFFFFFF
        reset = 1'b1; bus.count = 32'h7FFF_FFF8; bus.period = 32'd10;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.count = bus.count + ((i < 6) ? 32'd2 : 32'd1);
            tick();
        end
        chk("wrap_up_valid", 32'(bus.valid), 32'd1);
        chk("wrap_up_vel", bus.velocity, 32'h0000_0010);
        chk("wrap_up_pos", bus.position, 32'h8000_0008);

        // Downward wrap across zero
        reset = 1'b1; bus.count = 32'd5;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.count = bus.count - 32'd1;
            tick();
        end
        chk("wrap_dn_valid", 32'(bus.valid), 32'd1);
        chk("wrap_dn_vel", bus.velocity, 32'hFFFF_FFF6);
        chk("wrap_dn_pos", bus.position, 32'hFFFF_FFFB);

        // Period change mid-window only affects the next window
        reset = 1'b1; bus.count = 32'd0; bus.period = 32'd10;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) bus.period = 32'd4;
            bus.count = bus.count + 32'd1;
            tick();
        end
        chk("pchg_first", 32'(bus.valid), 32'd1);
        for (int k = 0; k < 2; k++) begin
            wait_valid(6, 1, n);
            chk("pchg_gap", 32'(n), 32'd4);
            chk("pchg_vel", bus.velocity, 32'd4);
        end

        // Disabled measurement, then enable with frozen count
        reset = 1'b1; bus.period = 32'd0;
        tick();
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 50; i++) begin
            bus.count = bus.count + 32'd1;
            tick();
            if (bus.valid) nv++;
        end
        chk("disabled_valids", 32'(nv), 32'd0);
        bus.count = 32'd7; bus.period = 32'd5;
        wait_valid(8, 0, n);
        chk("enable_latency", 32'(n), 32'd6);
        chk("enable_vel", bus.velocity, 32'd0);
        chk("enable_pos", bus.position, 32'd7);

        // Stall detection with period 3 and constant count
        reset = 1'b1; bus.count = 32'd1234; bus.period = 32'd3;
        tick();
        reset = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            wait_valid(4, 0, n);
            chk("stall_rise", 32'(bus.stalled), 32'(w == 4));
        end
        bus.count = bus.count + 32'd1; tick();
        bus.count = bus.count + 32'd1; tick();
        tick();
        chk("stall_clear_valid", 32'(bus.valid), 32'd1);
        chk("stall_clear_vel", bus.velocity, 32'd2);
        chk("stall_clear", 32'(bus.stalled), 32'd0);

        // Reset in the middle of a window
        reset = 1'b1; bus.count = 32'd0; bus.period = 32'd8;
        tick();
        reset = 1'b0;
        wait_valid(9, 1, n);
        for (int i = 0; i < 4; i++) begin
            bus.count = bus.count + 32'd1;
            tick();
        end
        reset = 1'b1; bus.count = bus.count + 32'd1;
        tick();
        reset = 1'b0;
        chk("midrst_vel", bus.velocity, 32'd0);
        chk("midrst_pos", bus.position, 32'd0);
        chk("midrst_valid", 32'(bus.valid), 32'd0);
        wait_valid(10, 1, n);
        chk("midrst_gap", 32'(n), 32'd8);

        // Randomized traffic: steps, frozen stretches, jumps, period changes, rare resets
        reset = 1'b1; bus.period = 32'($urandom_range(1, 6));
        tick();
        reset = 1'b0;
        frozen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 150 == 0) frozen = ~frozen;
            r = int'($urandom_range(0, 99));
            if (r < 4) bus.period = 32'($urandom_range(0, 6));
            reset = (r == 50);
            if (!frozen) begin
                if (r == 77) bus.count = $urandom();
                else bus.count = bus.count + 32'($urandom_range(0, 6)) - 32'd3;
            end
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
